// File: rtl/product_packetizer.sv
// product_packetizer: accumulates multiplier products into a dot product and emits it as a head/tail NoC packet
module product_packetizer #(
  parameter int ACC_W = 40,
  parameter logic [7:0] SRC_ID = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        prod_valid,
  input  logic [31:0] product,
  input  logic        prod_last,
  input  logic [7:0]  dest_id,
  output logic [33:0] flit_out,
  output logic        flit_valid,
  input  logic        flit_ready,
  output logic        busy,
  output logic        drop_err
);
  typedef enum logic [1:0] {IDLE, HEAD, TAIL} state_t;
  state_t state_q;
  logic [ACC_W-1:0] acc_q, sum_d;
  logic [7:0] cnt_q, n_d, dest_q;
  logic [31:0] data_q;
  logic [33:0] flit_q, head_d;
  logic valid_q, drop_q, sat_d, cap_d;
  // Next sum and term count, plus whether a finished sum can be taken by the output side
  always_comb begin
    sum_d = acc_q + {{(ACC_W-32){1'b0}}, product};
    n_d = (cnt_q == 8'hFF) ? 8'hFF : cnt_q + 8'd1;
    sat_d = |sum_d[ACC_W-1:32];
    cap_d = prod_valid & prod_last & ((state_q == IDLE) | ((state_q == TAIL) & flit_ready));
    head_d = {2'b01, dest_id, SRC_ID, n_d, sat_d, 7'b0};
  end
  // Accumulator, result capture and the head/tail output FSM with registered flit outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
      state_q <= IDLE;
      flit_q <= '0;
      valid_q <= 1'b0;
      drop_q <= 1'b0;
      dest_q <= '0;
      data_q <= '0;
    end else begin
      if (prod_valid) begin
        acc_q <= prod_last ? '0 : sum_d;
        cnt_q <= prod_last ? 8'd0 : n_d;
      end
      if (prod_valid & prod_last & !cap_d) drop_q <= 1'b1;
      if (cap_d) begin
        dest_q <= dest_id;
        data_q <= sat_d ? 32'hFFFF_FFFF : sum_d[31:0];
      end
      case (state_q)
        IDLE: if (cap_d) begin
          state_q <= HEAD;
          flit_q <= head_d;
          valid_q <= 1'b1;
        end
        HEAD: if (flit_ready) begin
          state_q <= TAIL;
          flit_q <= {2'b11, data_q};
        end
        TAIL: if (flit_ready) begin
          state_q <= cap_d ? HEAD : IDLE;
          flit_q <= cap_d ? head_d : flit_q;
          valid_q <= cap_d;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign flit_out = flit_q;
  assign flit_valid = valid_q;
  assign drop_err = drop_q;
  assign busy = (state_q != IDLE) | (cnt_q != 8'd0);
endmodule

// File: tb/tb_product_packetizer.sv
// tb_product_packetizer: directed checks of accumulation, packet format, stalls, drops and reset
module tb_product_packetizer;
  logic clk = 1'b0;
  logic rst, prod_valid, prod_last, flit_ready, flit_valid, busy, drop_err;
  logic [31:0] product;
  logic [7:0] dest_id;
  logic [33:0] flit_out;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  product_packetizer #(.ACC_W(40), .SRC_ID(8'h02)) dut (
    .clk(clk), .rst(rst), .prod_valid(prod_valid), .product(product),
    .prod_last(prod_last), .dest_id(dest_id), .flit_out(flit_out),
    .flit_valid(flit_valid), .flit_ready(flit_ready), .busy(busy), .drop_err(drop_err)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic term(input logic [31:0] p, input logic last, input logic [7:0] d);
    prod_valid = 1'b1;
    product = p;
    prod_last = last;
    dest_id = d;
    step();
    prod_valid = 1'b0;
    prod_last = 1'b0;
  endtask
  initial begin
    rst = 1'b1; prod_valid = 1'b0; prod_last = 1'b0; product = '0; dest_id = '0; flit_ready = 1'b1;
    step(); step();
    rst = 1'b0;
    chk("rst_valid", flit_valid, 0);
    chk("rst_out", flit_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_drop", drop_err, 0);
    term(100, 0, 0);
    term(200, 0, 0);
    chk("acc_busy", busy, 1);
    term(300, 1, 5);
    chk("p1_hvalid", flit_valid, 1);
    chk("p1_head", flit_out, 34'h1_0502_0300);
    step();
    chk("p1_tvalid", flit_valid, 1);
    chk("p1_tail", flit_out, 34'h3_0000_0258);
    step();
    chk("p1_idle", flit_valid, 0);
    chk("p1_busy", busy, 0);
    term(32'hFFFF_FFFF, 0, 0);
    term(32'hFFFF_FFFF, 1, 5);
    chk("sat_head", flit_out, 34'h1_0502_0280);
    step();
    chk("sat_tail", flit_out, 34'h3_FFFF_FFFF);
    step();
    chk("sat_idle", flit_valid, 0);
    flit_ready = 1'b0;
    term(7, 1, 5);
    chk("st_head", flit_out, 34'h1_0502_0100);
    term(4, 0, 0);
    chk("st_hold1", flit_out, 34'h1_0502_0100);
    chk("st_drop0", drop_err, 0);
    term(9, 1, 6);
    chk("st_hold2", flit_out, 34'h1_0502_0100);
    chk("st_drop1", drop_err, 1);
    term(10, 0, 0);
    chk("st_hold3", flit_out, 34'h1_0502_0100);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("st_holdv", flit_valid, 1);
      chk("st_holdn", flit_out, 34'h1_0502_0100);
    end
    flit_ready = 1'b1;
    step();
    chk("st_tail", flit_out, 34'h3_0000_0007);
    step();
    chk("st_idle", flit_valid, 0);
    term(5, 1, 7);
    chk("p3_head", flit_out, 34'h1_0702_0200);
    term(3, 0, 0);
    chk("p3_tail", flit_out, 34'h3_0000_000F);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_valid", flit_valid, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_drop", drop_err, 0);
    step();
    chk("mrst_quiet", flit_valid, 0);
    term(42, 1, 9);
    chk("one_head", flit_out, 34'h1_0902_0100);
    step();
    chk("one_tail", flit_out, 34'h3_0000_002A);
    term(8, 1, 3);
    chk("b2b_valid", flit_valid, 1);
    chk("b2b_head", flit_out, 34'h1_0302_0100);
    chk("b2b_drop", drop_err, 0);
    step();
    chk("b2b_tail", flit_out, 34'h3_0000_0008);
    step();
    chk("end_valid", flit_valid, 0);
    chk("end_busy", busy, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
